block_cnt_stats: RTL
====================

BLOCK_CNT_STATS -- requirements
Module: block_cnt_stats

Interface
REQ-001 Parameter FF_DLY, default 1, delay applied to every flip-flop assignment.
REQ-002 Parameter LEN_CNT, default 4, width of the incoming per-word block count.
REQ-003 Parameter LEN_WIN, default 8, width of the window-length input and the internal sample counter.
REQ-004 Parameter LEN_SUM, default 16, width of the window sum output.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 block_cnt  input  LEN_CNT  per-word block count from the upstream counter stage.
REQ-009 valid  input  1  one-cycle qualifier; block_cnt is a new sample in each cycle valid=1.
REQ-010 win_len  input  LEN_WIN  samples per window; 0 means 2^LEN_WIN.
REQ-011 clr  input  1  synchronous abort and flush.
REQ-012 stat_ready  input  1  consumer accepts the result.
REQ-013 stat_sum  output  LEN_SUM  saturating sum of window samples.
REQ-014 stat_max  output  LEN_CNT  largest sample in the window.
REQ-015 stat_min  output  LEN_CNT  smallest sample in the window.
REQ-016 stat_ovf  output  1  stat_sum saturated in this window.
REQ-017 stat_valid  output  1  result held and pending.
REQ-018 stat_drop  output  1  one-cycle pulse when a completed window is discarded.
REQ-019 busy  output  1  window in progress (state ACC).

Function
REQ-020 Input has no backpressure: every valid=1 cycle SHALL be consumed.
REQ-021 FSM states: IDLE and ACC. IDLE->ACC on valid=1 when win_len is not 1; IDLE->IDLE on valid=1 when win_len=1, with that sample completing a window.
REQ-022 win_len SHALL be captured on the first sample of each window; later changes take effect only at the next window.
REQ-023 The internal accumulators SHALL be loaded (not added) on a window's first sample: sum=block_cnt, max=min=block_cnt, sample count=1.
REQ-024 Each later sample SHALL add to sum, update max and min, and increment the count.
REQ-025 ACC->IDLE on the sample that makes count equal the captured length; that sample SHALL be included in the result.
REQ-026 Latency: stat_valid and the result registers SHALL update in the clock edge of the window's last sample, so they are visible the cycle after that valid.
REQ-027 Sum arithmetic SHALL saturate at 2^LEN_SUM-1 and set the window's ovf flag. With the default parameters saturation cannot occur (256*15=3840).
REQ-028 Output handshake: the result SHALL be held stable while stat_valid=1 and stat_ready=0. stat_valid SHALL clear on the edge where stat_valid=1 and stat_ready=1.
REQ-029 A window completing while a result is pending and not accepted in that cycle: the new result SHALL be discarded, stat_drop pulses, and the held result is unchanged.
REQ-030 A window completing in the same cycle that the pending result is accepted: the new result SHALL be loaded, and stat_valid stays 1.
REQ-031 A sample arriving the cycle after completion SHALL start a new window with no bubble, regardless of stat_valid.
REQ-032 clr=1 SHALL return the FSM to IDLE, zero the count, clear stat_valid, and ignore a coincident valid. clr takes priority over all other events.

Reset
REQ-033 On rst_n=0, asynchronously: state=IDLE; count, stat_sum, stat_max, stat_min, stat_ovf, stat_valid, stat_drop and busy =0; captured length=0.
REQ-034 Reset mid-window SHALL discard the partial window. The first valid after release SHALL start a fresh window.

Structure
REQ-035 A shared package SHALL hold the state encoding (IDLE=1'b0, ACC=1'b1) and the parameter defaults.
REQ-036 A single sub-module, sat_adder (LEN_SUM-wide saturating add with an overflow output), is natural. Everything else stays in the top module.

Verification
REQ-037 win_len=4, samples 3,0,7,2 back-to-back, stat_ready=1 -> one cycle after the 4th sample: sum=12, max=7, min=0, ovf=0, then stat_valid drops.
REQ-038 win_len=1, samples 5 then 9 on consecutive cycles, stat_ready=1 -> two consecutive results: (5,5,5) then (9,9,9).
REQ-039 win_len=2, stat_ready=0, two windows (1,2) then (4,4) -> held result sum=3, stat_drop pulses once on the second completion; stat_ready=1 then clears stat_valid.
REQ-040 win_len=0, 256 samples of 15 -> sum=3840, max=min=15; busy stays high until the 256th sample.
REQ-041 win_len=4, two samples, then clr=1 coincident with valid -> busy=0; the next 4 samples form a clean window.
REQ-042 rst_n pulsed low mid-window and while stat_valid=1 -> all outputs 0 immediately; the next window is correct.

Source files
------------

// File: rtl/block_cnt_stats_pkg.sv
`default_nettype none
// ============================================================================
// block_cnt_stats_pkg : shared state encoding and parameter defaults
// Rev 1.0
// ============================================================================
package block_cnt_stats_pkg;

    localparam int c_FF_DLY  = 1;
    localparam int c_LEN_CNT = 4;
    localparam int c_LEN_WIN = 8;
    localparam int c_LEN_SUM = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/block_cnt_stats_if.sv
`default_nettype none
// ============================================================================
// block_cnt_stats_if : sample input, window control and result handshake
// Rev 1.0
// ============================================================================
interface block_cnt_stats_if
    import block_cnt_stats_pkg::*;
#(
    parameter int LEN_CNT = c_LEN_CNT,
    parameter int LEN_WIN = c_LEN_WIN,
    parameter int LEN_SUM = c_LEN_SUM
) ();

    logic [LEN_CNT-1:0] block_cnt;
    logic               valid;
    logic [LEN_WIN-1:0] win_len;
    logic               clr;
    logic               stat_ready;
    logic [LEN_SUM-1:0] stat_sum;
    logic [LEN_CNT-1:0] stat_max;
    logic [LEN_CNT-1:0] stat_min;
    logic               stat_ovf;
    logic               stat_valid;
    logic               stat_drop;
    logic               busy;

    modport master (
        output block_cnt, valid, win_len, clr, stat_ready,
        input  stat_sum, stat_max, stat_min, stat_ovf, stat_valid, stat_drop, busy
    );

    modport slave (
        input  block_cnt, valid, win_len, clr, stat_ready,
        output stat_sum, stat_max, stat_min, stat_ovf, stat_valid, stat_drop, busy
    );

endinterface
`default_nettype wire

// File: rtl/block_cnt_stats_sat_adder.sv
`default_nettype none
// ============================================================================
// sat_adder : unsigned add that clamps to all-ones and flags the overflow
// Rev 1.0
// ============================================================================
module sat_adder
    import block_cnt_stats_pkg::*;
#(
    parameter int WIDTH = c_LEN_SUM
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic      [WIDTH-1:0] sum,
    output logic                  ovf
);

    logic [WIDTH:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b};
    assign ovf    = w_full[WIDTH];
    assign sum    = w_full[WIDTH] ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/block_cnt_stats.sv
`default_nettype none
// ============================================================================
// block_cnt_stats : per-window sum/max/min of block counts with held result
// Rev 1.0
// ============================================================================
module block_cnt_stats
    import block_cnt_stats_pkg::*;
#(
    parameter int FF_DLY  = c_FF_DLY,
    parameter int LEN_CNT = c_LEN_CNT,
    parameter int LEN_WIN = c_LEN_WIN,
    parameter int LEN_SUM = c_LEN_SUM
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    block_cnt_stats_if.slave bus
);

    localparam logic [LEN_WIN-1:0] c_WIN_ONE  = LEN_WIN'(1);
    localparam logic [LEN_WIN-1:0] c_WIN_ZERO = '0;

    // FF_DLY is carried for interface compatibility; registers update with zero delay.
    if (FF_DLY < 0 || LEN_SUM < LEN_CNT) begin : g_param_chk
        $error("block_cnt_stats: FF_DLY must be >= 0 and LEN_SUM >= LEN_CNT");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_first;
    logic               w_done;

    logic [LEN_WIN-1:0] r_len;
    logic [LEN_WIN-1:0] r_cnt;
    logic [LEN_WIN-1:0] w_cnt_inc;

    logic [LEN_SUM-1:0] r_acc_sum;
    logic [LEN_CNT-1:0] r_acc_max;
    logic [LEN_CNT-1:0] r_acc_min;
    logic               r_acc_ovf;

    logic [LEN_SUM-1:0] w_cnt_ext;
    logic [LEN_SUM-1:0] w_add_sum;
    logic               w_add_ovf;
    logic [LEN_SUM-1:0] w_win_sum;
    logic [LEN_CNT-1:0] w_win_max;
    logic [LEN_CNT-1:0] w_win_min;
    logic               w_win_ovf;

    logic [LEN_SUM-1:0] r_stat_sum;
    logic [LEN_CNT-1:0] r_stat_max;
    logic [LEN_CNT-1:0] r_stat_min;
    logic               r_stat_ovf;
    logic               r_stat_valid;
    logic               r_stat_drop;

    logic               w_accept;
    logic               w_load;
    logic               w_drop;

    assign w_cnt_inc = r_cnt + c_WIN_ONE;
    assign w_cnt_ext = LEN_SUM'(bus.block_cnt);

    sat_adder #(
        .WIDTH (LEN_SUM)
    ) u_sat_adder (
        .a   (r_acc_sum),
        .b   (w_cnt_ext),
        .sum (w_add_sum),
        .ovf (w_add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A window ends when the incremented count wraps onto the captured length,
    // so a captured length of 0 naturally means 2^LEN_WIN samples.
    always_comb begin
        w_state_nxt = r_state;
        w_first     = 1'b0;
        w_done      = 1'b0;
        if (bus.clr) begin
            w_state_nxt = ST_IDLE;
        end else if (bus.valid) begin
            case (r_state)
                ST_IDLE: begin
                    w_first = 1'b1;
                    if (bus.win_len == c_WIN_ONE) begin
                        w_done = 1'b1;
                    end else begin
                        w_state_nxt = ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (w_cnt_inc == r_len) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_win_sum = w_first ? w_cnt_ext : w_add_sum;
        w_win_ovf = w_first ? 1'b0 : (r_acc_ovf | w_add_ovf);
        w_win_max = (w_first || (bus.block_cnt > r_acc_max)) ? bus.block_cnt : r_acc_max;
        w_win_min = (w_first || (bus.block_cnt < r_acc_min)) ? bus.block_cnt : r_acc_min;
    end

    assign w_accept = r_stat_valid & bus.stat_ready;
    assign w_load   = w_done & (~r_stat_valid | bus.stat_ready);
    assign w_drop   = w_done & r_stat_valid & ~bus.stat_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len        <= c_WIN_ZERO;
            r_cnt        <= c_WIN_ZERO;
            r_acc_sum    <= '0;
            r_acc_max    <= '0;
            r_acc_min    <= '0;
            r_acc_ovf    <= 1'b0;
            r_stat_sum   <= '0;
            r_stat_max   <= '0;
            r_stat_min   <= '0;
            r_stat_ovf   <= 1'b0;
            r_stat_valid <= 1'b0;
            r_stat_drop  <= 1'b0;
        end else if (bus.clr) begin
            r_cnt        <= c_WIN_ZERO;
            r_stat_valid <= 1'b0;
            r_stat_drop  <= 1'b0;
        end else begin
            r_stat_drop <= w_drop;
            if (bus.valid) begin
                if (w_first) begin
                    r_len <= bus.win_len;
                end
                r_cnt     <= w_first ? c_WIN_ONE : w_cnt_inc;
                r_acc_sum <= w_win_sum;
                r_acc_max <= w_win_max;
                r_acc_min <= w_win_min;
                r_acc_ovf <= w_win_ovf;
            end
            if (w_load) begin
                r_stat_sum   <= w_win_sum;
                r_stat_max   <= w_win_max;
                r_stat_min   <= w_win_min;
                r_stat_ovf   <= w_win_ovf;
                r_stat_valid <= 1'b1;
            end else if (w_accept) begin
                r_stat_valid <= 1'b0;
            end
        end
    end

    assign bus.stat_sum   = r_stat_sum;
    assign bus.stat_max   = r_stat_max;
    assign bus.stat_min   = r_stat_min;
    assign bus.stat_ovf   = r_stat_ovf;
    assign bus.stat_valid = r_stat_valid;
    assign bus.stat_drop  = r_stat_drop;
    assign bus.busy       = (r_state == ST_ACC);

endmodule
`default_nettype wire
